// File: rtl/seg7_scan_driver.sv
// Time-multiplexed BCD-to-7-segment driver with tear-free frame-boundary updates,
// per-digit blinking, leading-zero suppression and selectable pin polarity.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                phase_q, phase_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                fdone_q, fdone_d;

  logic       lastCnt, lastIdx, boundary, blank, lzHit, zeroRun;
  logic [3:0] curDigit;
  logic [6:0] segRaw;

  function automatic logic [6:0] decodeBcd(input logic [3:0] d);
    case (d)
      4'd0:    decodeBcd = 7'b1111110;
      4'd1:    decodeBcd = 7'b0110000;
      4'd2:    decodeBcd = 7'b1101101;
      4'd3:    decodeBcd = 7'b1111001;
      4'd4:    decodeBcd = 7'b0110011;
      4'd5:    decodeBcd = 7'b1011011;
      4'd6:    decodeBcd = 7'b1011111;
      4'd7:    decodeBcd = 7'b1110000;
      4'd8:    decodeBcd = 7'b1111111;
      4'd9:    decodeBcd = 7'b1111011;
      default: decodeBcd = 7'b0000001;
    endcase
  endfunction

  // Outputs are computed from next-state values so the pins line up with the
  // cnt/idx they represent without an extra cycle of lag.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frm_d    = frm_q;
    phase_d  = phase_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    lastCnt  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    lastIdx  = (idx_q == IDX_W'(DIGITS - 1));
    boundary = en && lastCnt && lastIdx;

    if (en) begin
      if (lastCnt) begin
        cnt_d = '0;
        idx_d = lastIdx ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (boundary) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    if (load) begin
      shadow_d = bcd;
      pend_d   = 1'b1;
    end
    // Going through shadow_d gives the same-edge load bypass for free.
    if ((!en || boundary) && pend_d) begin
      disp_d = shadow_d;
      pend_d = 1'b0;
    end

    curDigit = disp_d[4*idx_d +: 4];
    zeroRun  = 1'b1;
    lzHit    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroRun = zeroRun && (disp_d[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == idx_d) lzHit = zeroRun;
    end
    blank = (phase_d && blink_en[idx_d]) || (blank_lz && (idx_d != '0) && lzHit);

    segRaw  = decodeBcd(curDigit);
    seg_d   = SEG_OFF;
    dig_d   = DIG_OFF;
    fdone_d = boundary;
    if (en && (cnt_d != '0)) begin
      dig_d = DIG_ACTIVE_LOW ? ~(DIGITS'(1) << idx_d) : (DIGITS'(1) << idx_d);
      if (!blank) seg_d = SEG_ACTIVE_LOW ? ~segRaw : segRaw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      frm_q    <= '0;
      phase_q  <= 1'b0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      disp_q   <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      fdone_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fdone_q  <= fdone_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-position reference model.
module tb_seg7_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load, blank_lz;
  logic [15:0] bcd;
  logic [3:0]  blink_en;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: position within the frame plus the shown/queued words.
  int          pos, frames, phase, pend;
  logic [15:0] disp, shadow;
  logic [6:0]  expSeg;
  logic [3:0]  expDig;
  logic        expFd;
  logic [6:0]  segTable [0:15];

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd(bcd),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .seg(seg), .dig(dig), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h want %h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    pos = 0; frames = 0; phase = 0; pend = 0;
    disp = '0; shadow = '0;
    expSeg = 7'h7F; expDig = 4'hF; expFd = 1'b0;
  endtask

  task automatic modelStep();
    int slot, offset;
    bit boundary, blank;
    boundary = en && (pos == FRAME_LEN - 1);
    if (en) pos = (pos + 1) % FRAME_LEN;
    if (load) begin
      shadow = bcd;
      pend   = 1;
    end
    if ((!en || boundary) && pend != 0) begin
      disp = shadow;
      pend = 0;
    end
    if (boundary) begin
      frames++;
      if (frames == BLINK_FRAMES) begin
        frames = 0;
        phase  = 1 - phase;
      end
    end
    expFd  = boundary;
    slot   = pos / SCAN_DIV;
    offset = pos % SCAN_DIV;
    expSeg = 7'h7F;
    expDig = 4'hF;
    if (en && offset != 0) begin
      expDig = ~(4'(1) << slot);
      blank  = (phase == 1 && blink_en[slot]) ||
               (blank_lz && slot > 0 && (int'(disp) >> (4 * slot)) == 0);
      if (!blank) expSeg = ~segTable[(int'(disp) >> (4 * slot)) & 15];
    end
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic [15:0] b,
                               input logic blz, input logic [3:0] blk);
    en = e; load = l; bcd = b; blank_lz = blz; blink_en = blk;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("seg", 32'(seg), 32'(expSeg));
    checkOutput("dig", 32'(dig), 32'(expDig));
    checkOutput("frame_done", 32'(frame_done), 32'(expFd));
  endtask

  task automatic midReset();
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_seg", 32'(seg), 32'(expSeg));
    checkOutput("rst_dig", 32'(dig), 32'(expDig));
    checkOutput("rst_fd", 32'(frame_done), 32'(expFd));
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] randBcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 7) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    logic        rEn, rLoad, rBlz;
    logic [3:0]  rBlk;
    segTable = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                 7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd = '0; blank_lz = 1'b0; blink_en = '0;
    modelReset();
    @(negedge clk);
    checkOutput("reset_seg", 32'(seg), 32'(expSeg));
    checkOutput("reset_dig", 32'(dig), 32'(expDig));
    checkOutput("reset_fd", 32'(frame_done), 32'(expFd));
    #2 rst_n = 1'b1;

    // Directed opening: plain load, double load in one frame, lz and dash cases.
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 4'b0000);
    repeat (2 * FRAME_LEN) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 4'b0000);
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 16'h5678, 1'b0, 4'b0000);
    repeat (2 * FRAME_LEN) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    foreach (segTable[k]) if (k < 3) begin
      applyStimulus(1'b1, 1'b1, (k == 0) ? 16'h0007 : (k == 1) ? 16'h0000 : 16'h0A05, 1'b1, 4'b0000);
      repeat (2 * FRAME_LEN) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 4'b0000);
    end
    repeat (6 * FRAME_LEN) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0010);
    repeat (5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    repeat (10) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    repeat (FRAME_LEN) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 16'h9876, 1'b0, 4'b0000);
    midReset();
    repeat (2 * FRAME_LEN) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);

    rBlz = 1'b0;
    rBlk = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      rEn   = ($urandom_range(0, 19) != 0);
      rLoad = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) rBlz = ~rBlz;
      if ($urandom_range(0, 149) == 0) rBlk = 4'($urandom_range(0, 15));
      applyStimulus(rEn, rLoad, randBcd(), rBlz, rBlk);
      if ($urandom_range(0, 499) == 0) midReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
